// File: rtl/decode_stage_if.sv
// Handshake bundle between the fetch buffer, the decode stage and the register-read stage.
// master = upstream/downstream environment view, slave = the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN               = 32,
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int TYPE_WIDTH         = 3,
    parameter int REGISTER_WIDTH     = 5,
    parameter int FLAG_WIDTH         = 8,
    parameter int COUNT_WIDTH        = 16
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [INSTRUCTION_LENGTH-1:0] instruction;
    logic                          out_valid;
    logic                          out_ready;
    logic [TYPE_WIDTH-1:0]         out_type;
    logic [REGISTER_WIDTH-1:0]     rd;
    logic [REGISTER_WIDTH-1:0]     rs1;
    logic [REGISTER_WIDTH-1:0]     rs2;
    logic [XLEN-1:0]               imm;
    logic [FLAG_WIDTH-1:0]         flag;
    logic [COUNT_WIDTH-1:0]        decoded_count;

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, out_type, rd, rs1, rs2, imm, flag, decoded_count
    );

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, out_type, rd, rs1, rs2, imm, flag, decoded_count
    );

endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: combinational field/immediate decode captured into a
// 2-entry (head + skid) buffer with valid/ready handshake, flush and a pop counter.
module decode_stage #(
    parameter int XLEN               = 32,
    parameter int INSTRUCTION_LENGTH = 32,
    parameter int TYPE_WIDTH         = 3,
    parameter int REGISTER_WIDTH     = 5,
    parameter int FLAG_WIDTH         = 8,
    parameter int COUNT_WIDTH        = 16
) (
    input logic           clk,
    input logic           reset_n,
    input logic           flush,
    decode_stage_if.slave bus
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    localparam logic [TYPE_WIDTH-1:0] TYPE_R   = TYPE_WIDTH'(3'd0);
    localparam logic [TYPE_WIDTH-1:0] TYPE_I   = TYPE_WIDTH'(3'd1);
    localparam logic [TYPE_WIDTH-1:0] TYPE_S   = TYPE_WIDTH'(3'd2);
    localparam logic [TYPE_WIDTH-1:0] TYPE_SB  = TYPE_WIDTH'(3'd3);
    localparam logic [TYPE_WIDTH-1:0] TYPE_U   = TYPE_WIDTH'(3'd4);
    localparam logic [TYPE_WIDTH-1:0] TYPE_UJ  = TYPE_WIDTH'(3'd5);
    localparam logic [TYPE_WIDTH-1:0] TYPE_ILL = TYPE_WIDTH'(3'd7);

    localparam logic [FLAG_WIDTH-1:0] FLAG_R   = FLAG_WIDTH'(8'h07);
    localparam logic [FLAG_WIDTH-1:0] FLAG_I   = FLAG_WIDTH'(8'h0B);
    localparam logic [FLAG_WIDTH-1:0] FLAG_SSB = FLAG_WIDTH'(8'h0E);
    localparam logic [FLAG_WIDTH-1:0] FLAG_U   = FLAG_WIDTH'(8'h09);
    localparam logic [FLAG_WIDTH-1:0] FLAG_ILL = FLAG_WIDTH'(8'h80);

    localparam bit IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic [TYPE_WIDTH-1:0]     typ;
        logic [REGISTER_WIDTH-1:0] rd;
        logic [REGISTER_WIDTH-1:0] rs1;
        logic [REGISTER_WIDTH-1:0] rs2;
        logic [XLEN-1:0]           imm;
        logic [FLAG_WIDTH-1:0]     flag;
    } entryT;

    logic [INSTRUCTION_LENGTH-1:0] instrWord;
    logic [6:0]                    opcode;
    logic signed [31:0]            rawImm;
    entryT                         decWord;

    logic [1:0]             state_q, state_d;
    entryT                  head_q, head_d;
    entryT                  skid_q, skid_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic inReady;
    logic outValid;
    logic acceptWord;
    logic popWord;

    assign instrWord = bus.instruction;
    assign opcode    = instrWord[6:0];

    // Opcode classification; the two RV64-only opcodes fall through to illegal on RV32.
    always_comb begin
        decWord     = '0;
        rawImm      = '0;
        decWord.rd  = instrWord[11:7];
        decWord.rs1 = instrWord[19:15];
        decWord.rs2 = instrWord[24:20];
        decWord.typ = TYPE_ILL;
        case (opcode)
            7'b0110011:                         decWord.typ = TYPE_R;
            7'b0111011: if (IS_RV64)            decWord.typ = TYPE_R;
            7'b0010011, 7'b0000011,
            7'b1100111, 7'b1110011:             decWord.typ = TYPE_I;
            7'b0011011: if (IS_RV64)            decWord.typ = TYPE_I;
            7'b0100011:                         decWord.typ = TYPE_S;
            7'b1100011:                         decWord.typ = TYPE_SB;
            7'b0110111, 7'b0010111:             decWord.typ = TYPE_U;
            7'b1101111:                         decWord.typ = TYPE_UJ;
            default:                            decWord.typ = TYPE_ILL;
        endcase

        case (decWord.typ)
            TYPE_R: begin
                decWord.flag = FLAG_R;
            end
            TYPE_I: begin
                decWord.flag = FLAG_I;
                rawImm       = 32'($signed(instrWord[31:20]));
            end
            TYPE_S: begin
                decWord.flag = FLAG_SSB;
                rawImm       = 32'($signed({instrWord[31:25], instrWord[11:7]}));
            end
            TYPE_SB: begin
                decWord.flag = FLAG_SSB;
                rawImm       = 32'($signed({instrWord[31], instrWord[7], instrWord[30:25],
                                            instrWord[11:8], 1'b0}));
            end
            TYPE_U: begin
                decWord.flag = FLAG_U;
                rawImm       = {instrWord[31:12], 12'b0};
            end
            TYPE_UJ: begin
                decWord.flag = FLAG_U;
                rawImm       = 32'($signed({instrWord[31], instrWord[19:12], instrWord[20],
                                            instrWord[30:21], 1'b0}));
            end
            default: begin
                decWord.flag = FLAG_ILL;
            end
        endcase

        // Signed size cast widens with the sign bit, giving RV64 LUI semantics for U-type.
        decWord.imm = XLEN'(rawImm);
    end

    assign inReady    = (state_q != FULL);
    assign outValid   = (state_q != EMPTY);
    assign acceptWord = bus.in_valid & inReady;
    assign popWord    = outValid & bus.out_ready;

    // Buffer occupancy: the head always feeds the outputs, the skid only holds the second word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;
        case (state_q)
            EMPTY: begin
                if (acceptWord) begin
                    head_d  = decWord;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (acceptWord && popWord) begin
                    head_d = decWord;
                end else if (acceptWord) begin
                    skid_d  = decWord;
                    state_d = FULL;
                end else if (popWord) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (popWord) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (popWord) begin
            count_d = count_q + COUNT_WIDTH'(1);
        end

        // A flush discards both buffered entries and the word on the input, and the pop is not counted.
        if (flush) begin
            state_d = EMPTY;
            head_d  = head_q;
            skid_d  = skid_q;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready      = inReady;
    assign bus.out_valid     = outValid;
    assign bus.out_type      = head_q.typ;
    assign bus.rd            = head_q.rd;
    assign bus.rs1           = head_q.rs1;
    assign bus.rs2           = head_q.rs2;
    assign bus.imm           = head_q.imm;
    assign bus.flag          = head_q.flag;
    assign bus.decoded_count = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Drives an RV32 (4-bit counter) and an RV64 (16-bit counter) decode stage in lockstep
// and scores both against a queue-based model of the two-entry buffer.
module tb_decode_stage;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_SB = 3'd3;
    localparam logic [2:0] T_U = 3'd4, T_UJ = 3'd5, T_ILL = 3'd7;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  typ32, typ64;
        logic [7:0]  flg32, flg64;
        logic [63:0] imm32, imm64;
    } expT;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        flushIn = 1'b0;
    logic        inValid = 1'b0;
    logic [31:0] instrIn = '0;
    logic        outReady = 1'b0;

    int  passedCount = 0;
    int  totalCount = 0;
    bit  modelLive = 1'b0;
    int  cnt32 = 0;
    int  cnt64 = 0;
    expT expQ[$];

    logic [6:0] opList [14] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h73, 7'h1B,
                                7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};

    decode_stage_if #(.XLEN(32), .COUNT_WIDTH(4))  bus32 ();
    decode_stage_if #(.XLEN(64), .COUNT_WIDTH(16)) bus64 ();

    decode_stage #(.XLEN(32), .INSTRUCTION_LENGTH(32), .TYPE_WIDTH(3), .REGISTER_WIDTH(5),
                   .FLAG_WIDTH(8), .COUNT_WIDTH(4)) dut32 (
        .clk(clk), .reset_n(resetN), .flush(flushIn), .bus(bus32));

    decode_stage #(.XLEN(64), .INSTRUCTION_LENGTH(32), .TYPE_WIDTH(3), .REGISTER_WIDTH(5),
                   .FLAG_WIDTH(8), .COUNT_WIDTH(16)) dut64 (
        .clk(clk), .reset_n(resetN), .flush(flushIn), .bus(bus64));

    assign bus32.in_valid    = inValid;
    assign bus32.instruction = instrIn;
    assign bus32.out_ready   = outReady;
    assign bus64.in_valid    = inValid;
    assign bus64.instruction = instrIn;
    assign bus64.out_ready   = outReady;

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        totalCount++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end else begin
            passedCount++;
        end
    endtask

    // Reference decode written from the instruction-format rules using plain arithmetic.
    function automatic void refDecode(input logic [31:0] w, input bit is64,
                                      output logic [2:0] t, output logic [7:0] f,
                                      output logic [63:0] im);
        longint v = 0;
        t = T_ILL;
        case (w[6:0])
            7'h33: t = T_R;
            7'h3B: t = is64 ? T_R : T_ILL;
            7'h13, 7'h03, 7'h67, 7'h73: t = T_I;
            7'h1B: t = is64 ? T_I : T_ILL;
            7'h23: t = T_S;
            7'h63: t = T_SB;
            7'h37, 7'h17: t = T_U;
            7'h6F: t = T_UJ;
            default: t = T_ILL;
        endcase
        case (t)
            T_R: f = 8'h07;
            T_I: begin
                f = 8'h0B;
                v = longint'(w[31:20]);
                if (v >= 2048) v -= 4096;
            end
            T_S: begin
                f = 8'h0E;
                v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
                if (v >= 2048) v -= 4096;
            end
            T_SB: begin
                f = 8'h0E;
                v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048
                  + longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            T_U: begin
                f = 8'h09;
                v = longint'(w[31:12]) * 4096;
                if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end
            T_UJ: begin
                f = 8'h09;
                v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096
                  + longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
                if (v >= 1048576) v -= 2097152;
            end
            default: f = 8'h80;
        endcase
        im = is64 ? 64'(v) : {32'b0, 32'(v)};
    endfunction

    function automatic expT makeExp(input logic [31:0] w);
        expT e;
        e.word = w;
        refDecode(w, 1'b0, e.typ32, e.flg32, e.imm32);
        refDecode(w, 1'b1, e.typ64, e.flg64, e.imm64);
        return e;
    endfunction

    // Monitor: compares handshake/count each cycle, pops on consumer handshake, pushes on accept.
    initial begin
        forever begin
            int  sz;
            expT e;
            @(negedge clk);
            sz = expQ.size();
            if (modelLive) begin
                checkOutput("in_ready32", bus32.in_ready, sz < 2);
                checkOutput("in_ready64", bus64.in_ready, sz < 2);
                checkOutput("out_valid32", bus32.out_valid, sz > 0);
                checkOutput("out_valid64", bus64.out_valid, sz > 0);
                checkOutput("count32", bus32.decoded_count, cnt32);
                checkOutput("count64", bus64.decoded_count, cnt64);
            end
            if (modelLive && resetN && !flushIn && outReady && sz > 0) begin
                e = expQ.pop_front();
                checkOutput("type32", bus32.out_type, e.typ32);
                checkOutput("flag32", bus32.flag, e.flg32);
                checkOutput("imm32", bus32.imm, e.imm32);
                checkOutput("rd32", bus32.rd, e.word[11:7]);
                checkOutput("rs1_32", bus32.rs1, e.word[19:15]);
                checkOutput("rs2_32", bus32.rs2, e.word[24:20]);
                checkOutput("type64", bus64.out_type, e.typ64);
                checkOutput("flag64", bus64.flag, e.flg64);
                checkOutput("imm64", bus64.imm, e.imm64);
                checkOutput("rd64", bus64.rd, e.word[11:7]);
                checkOutput("rs1_64", bus64.rs1, e.word[19:15]);
                checkOutput("rs2_64", bus64.rs2, e.word[24:20]);
                cnt32 = (cnt32 + 1) % 16;
                cnt64 = (cnt64 + 1) % 65536;
            end
            if (modelLive && resetN && !flushIn && inValid && sz < 2) begin
                expQ.push_back(makeExp(instrIn));
            end
            if (!resetN) begin
                expQ.delete();
                cnt32 = 0;
                cnt64 = 0;
                modelLive = 1'b1;
            end else if (flushIn) begin
                expQ.delete();
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [31:0] w, input logic r,
                                 input logic fl, input logic rn);
        @(posedge clk);
        #1;
        inValid  = v;
        instrIn  = w;
        outReady = r;
        flushIn  = fl;
        resetN   = rn;
    endtask

    function automatic logic [31:0] randWord();
        logic [31:0] r;
        int          idx;
        r   = $urandom();
        idx = $urandom_range(0, 15);
        if (idx < 14) r[6:0] = opList[idx];
        return r;
    endfunction

    initial begin
        $display("[TB] decode_stage bench start");
        applyStimulus(1, 32'h0000_0013, 1, 0, 0);
        applyStimulus(1, 32'h0000_0013, 1, 0, 0);
        applyStimulus(0, 32'h0, 1, 0, 1);
        checkOutput("reset_type32", bus32.out_type, 0);
        checkOutput("reset_imm32", bus32.imm, 0);
        checkOutput("reset_flag32", bus32.flag, 0);
        checkOutput("reset_regs32", {bus32.rd, bus32.rs1, bus32.rs2}, 0);
        checkOutput("reset_type64", bus64.out_type, 0);
        checkOutput("reset_imm64", bus64.imm, 0);
        checkOutput("reset_flag64", bus64.flag, 0);

        applyStimulus(1, 32'hFFF1_0093, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(1, 32'h0051_2423, 1, 0, 1);
        applyStimulus(1, 32'hFE00_0EE3, 1, 0, 1);
        applyStimulus(1, 32'h8000_00B7, 1, 0, 1);
        applyStimulus(1, 32'h0000_007F, 1, 0, 1);
        applyStimulus(1, 32'h0000_003B, 1, 0, 1);
        applyStimulus(1, 32'hFFF0_001B, 1, 0, 1);
        applyStimulus(1, 32'h8000_006F, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);

        // Back-pressure: two absorbed, third held until the first pop frees a slot.
        applyStimulus(1, 32'h0010_0093, 0, 0, 1);
        applyStimulus(1, 32'h0020_0113, 0, 0, 1);
        applyStimulus(1, 32'h0030_0193, 0, 0, 1);
        applyStimulus(1, 32'h0030_0193, 0, 0, 1);
        applyStimulus(1, 32'h0030_0193, 1, 0, 1);
        applyStimulus(1, 32'h0030_0193, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);

        // Flush from FULL with a word and a pop presented.
        applyStimulus(1, 32'h0040_0213, 0, 0, 1);
        applyStimulus(1, 32'h0050_0293, 0, 0, 1);
        applyStimulus(1, 32'h0060_0313, 1, 1, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);

        // Reset mid-stream with a word presented in the reset cycle.
        applyStimulus(1, 32'h0070_0393, 0, 0, 1);
        applyStimulus(1, 32'h0080_0413, 1, 0, 0);
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);

        // Counter wrap: 17 pops on a 4-bit counter leaves 1.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, randWord(), 1, 0, 1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 1, 0, 1);
        end
        checkOutput("wrap_count32", bus32.decoded_count, 1);
        checkOutput("wrap_count64", bus64.decoded_count, 17);

        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, randWord(), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 31) == 0, $urandom_range(0, 63) != 0);
        end
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);
        applyStimulus(0, 32'h0, 1, 0, 1);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passedCount, totalCount);
        $finish;
    end

endmodule
